// File: rtl/fwd_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_ctrl_unit
// Purpose  : Operand forwarding and load-use hazard control for a 5-stage
//            in-order pipeline. Tracks the destination of every instruction
//            in EX, MEM, WB and (optionally) post-writeback, and steers the
//            EX-stage operand muxes to the youngest in-flight producer.
// Revision : 1.0 - initial release
//
// Ports
//   CLK          in   1  clock, rising edge
//   RESET        in   1  asynchronous reset, active low
//   ID_RS1/RS2   in   5  source registers of the instruction in ID
//   ID_RD        in   5  destination register of the instruction in ID
//   ID_WRITE_EN  in   1  ID instruction writes ID_RD
//   ID_MEM_READ  in   1  ID instruction is a load
//   HOLD         in   1  freeze all stage records (multi-cycle unit busy)
//   FLUSH        in   1  turn the instruction entering EX into a bubble
//   FWD_SEL_A/B  out  2  operand mux selects: 00 RF, 01 MEM, 10 WB, 11 PWB
//   STALL        out  1  load-use hazard, IF/ID must hold this cycle
//
// Configuration
//   FWD_POST_WB_EN  when defined, adds the post-writeback record and select
//                   11 for register files without write-through.
// ============================================================================
module fwd_ctrl_unit (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [4:0] ID_RS1,
    input  logic [4:0] ID_RS2,
    input  logic [4:0] ID_RD,
    input  logic       ID_WRITE_EN,
    input  logic       ID_MEM_READ,
    input  logic       HOLD,
    input  logic       FLUSH,
    output logic [1:0] FWD_SEL_A,
    output logic [1:0] FWD_SEL_B,
    output logic       STALL
);

    localparam logic [1:0] C_SEL_RF  = 2'b00;
    localparam logic [1:0] C_SEL_MEM = 2'b01;
    localparam logic [1:0] C_SEL_WB  = 2'b10;
`ifdef FWD_POST_WB_EN
    localparam logic [1:0] C_SEL_PWB = 2'b11;
`endif

    // Stage records
    logic [4:0] r_ex_rs1, r_ex_rs2, r_ex_rd;
    logic       r_ex_we,  r_ex_mr;
    logic [4:0] r_mem_rd;
    logic       r_mem_we, r_mem_mr;
    logic [4:0] r_wb_rd;
    logic       r_wb_we,  r_wb_mr;
`ifdef FWD_POST_WB_EN
    logic [4:0] r_pwb_rd;
    logic       r_pwb_we, r_pwb_mr;
`endif

    logic       w_stall;
    logic       w_bubble;

    // Load in EX whose result is needed by the instruction now in ID.
    // Suppressed while frozen so a held pipeline never requests a bubble.
    assign w_stall = ~HOLD & r_ex_mr & r_ex_we & (r_ex_rd != 5'd0) &
                     ((r_ex_rd == ID_RS1) | (r_ex_rd == ID_RS2));

    assign w_bubble = w_stall | FLUSH;
    assign STALL    = w_stall;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_ex_rs1 <= 5'd0;
            r_ex_rs2 <= 5'd0;
            r_ex_rd  <= 5'd0;
            r_ex_we  <= 1'b0;
            r_ex_mr  <= 1'b0;
            r_mem_rd <= 5'd0;
            r_mem_we <= 1'b0;
            r_mem_mr <= 1'b0;
            r_wb_rd  <= 5'd0;
            r_wb_we  <= 1'b0;
            r_wb_mr  <= 1'b0;
`ifdef FWD_POST_WB_EN
            r_pwb_rd <= 5'd0;
            r_pwb_we <= 1'b0;
            r_pwb_mr <= 1'b0;
`endif
        end else if (!HOLD) begin
            if (w_bubble) begin
                r_ex_rs1 <= 5'd0;
                r_ex_rs2 <= 5'd0;
                r_ex_rd  <= 5'd0;
                r_ex_we  <= 1'b0;
                r_ex_mr  <= 1'b0;
            end else begin
                r_ex_rs1 <= ID_RS1;
                r_ex_rs2 <= ID_RS2;
                r_ex_rd  <= ID_RD;
                r_ex_we  <= ID_WRITE_EN;
                r_ex_mr  <= ID_MEM_READ;
            end
            r_mem_rd <= r_ex_rd;
            r_mem_we <= r_ex_we;
            r_mem_mr <= r_ex_mr;
            r_wb_rd  <= r_mem_rd;
            r_wb_we  <= r_mem_we;
            r_wb_mr  <= r_mem_mr;
`ifdef FWD_POST_WB_EN
            r_pwb_rd <= r_wb_rd;
            r_pwb_we <= r_wb_we;
            r_pwb_mr <= r_wb_mr;
`endif
        end
    end

    // A load sitting in MEM has no data yet; the load-use bubble keeps a
    // consumer from ever meeting it there, and the extra term makes sure a
    // MEM load can never be picked even if that invariant were broken.
    function automatic logic [1:0] f_sel(
        input logic [4:0] rs,
        input logic [4:0] mem_rd, input logic mem_we, input logic mem_mr,
        input logic [4:0] wb_rd,  input logic wb_we,
        input logic [4:0] pwb_rd, input logic pwb_we
    );
        logic [1:0] sel;
        sel = C_SEL_RF;
        if (rs == 5'd0) begin
            sel = C_SEL_RF;
        end else if (mem_we && !mem_mr && (mem_rd == rs)) begin
            sel = C_SEL_MEM;
        end else if (wb_we && (wb_rd == rs)) begin
            sel = C_SEL_WB;
`ifdef FWD_POST_WB_EN
        end else if (pwb_we && (pwb_rd == rs)) begin
            sel = C_SEL_PWB;
`endif
        end
`ifndef FWD_POST_WB_EN
        // PWB arguments are tied off in this build.
        if (pwb_we && (pwb_rd == 5'h1f)) sel = sel;
`endif
        return sel;
    endfunction

    logic [4:0] w_pwb_rd;
    logic       w_pwb_we;
    logic       w_unused;
`ifdef FWD_POST_WB_EN
    assign w_pwb_rd = r_pwb_rd;
    assign w_pwb_we = r_pwb_we;
    assign w_unused = r_wb_mr ^ r_pwb_mr;
`else
    assign w_pwb_rd = 5'd0;
    assign w_pwb_we = 1'b0;
    assign w_unused = r_wb_mr;
`endif

    always_comb begin
        FWD_SEL_A = f_sel(r_ex_rs1, r_mem_rd, r_mem_we, r_mem_mr,
                          r_wb_rd, r_wb_we, w_pwb_rd, w_pwb_we);
        FWD_SEL_B = f_sel(r_ex_rs2, r_mem_rd, r_mem_we, r_mem_mr,
                          r_wb_rd, r_wb_we, w_pwb_rd, w_pwb_we);
    end

endmodule
`default_nettype wire

// File: tb/tb_fwd_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_ctrl_unit
// Purpose  : Directed self-checking bench for fwd_ctrl_unit. Inputs change
//            1 time unit after the rising edge; outputs are checked after
//            they settle, well before the next edge.
// Revision : 1.0 - initial release
// Configuration: FWD_POST_WB_EN selects the expected three-ahead result.
// ============================================================================
module tb_fwd_ctrl_unit;

    logic       CLK;
    logic       RESET;
    logic [4:0] ID_RS1, ID_RS2, ID_RD;
    logic       ID_WRITE_EN, ID_MEM_READ;
    logic       HOLD, FLUSH;
    logic [1:0] FWD_SEL_A, FWD_SEL_B;
    logic       STALL;

    int tests_run = 0;
    int tests_failed = 0;

    fwd_ctrl_unit u_dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ID_RS1     (ID_RS1),
        .ID_RS2     (ID_RS2),
        .ID_RD      (ID_RD),
        .ID_WRITE_EN(ID_WRITE_EN),
        .ID_MEM_READ(ID_MEM_READ),
        .HOLD       (HOLD),
        .FLUSH      (FLUSH),
        .FWD_SEL_A  (FWD_SEL_A),
        .FWD_SEL_B  (FWD_SEL_B),
        .STALL      (STALL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [1:0] a, input logic [1:0] b, input logic s);
        chk({tag, ".A"}, FWD_SEL_A, a);
        chk({tag, ".B"}, FWD_SEL_B, b);
        chk({tag, ".STALL"}, {1'b0, STALL}, {1'b0, s});
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic we, input logic mr);
        ID_RS1 = rs1; ID_RS2 = rs2; ID_RD = rd;
        ID_WRITE_EN = we; ID_MEM_READ = mr;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        issue(0, 0, 0, 0, 0);
        repeat (4) tick();
    endtask

    initial begin
        RESET = 1'b0; HOLD = 1'b0; FLUSH = 1'b0;
        ID_RS1 = 0; ID_RS2 = 0; ID_RD = 0; ID_WRITE_EN = 0; ID_MEM_READ = 0;
        #12;
        chk3("reset", 2'b00, 2'b00, 1'b0);
        RESET = 1'b1;
        tick();
        chk3("post_reset_empty", 2'b00, 2'b00, 1'b0);

        // Back-to-back dependency: MEM forwarding on A only
        issue(0, 0, 5, 1, 0); tick();
        issue(5, 0, 0, 0, 0); tick();
        chk("adj.A", FWD_SEL_A, 2'b01);
        chk("adj.B", FWD_SEL_B, 2'b00);

        // Two producers of x5, the younger wins; A and B both forward
        drain();
        issue(0, 0, 5, 1, 0); tick();
        issue(0, 0, 5, 1, 0); tick();
        issue(5, 5, 0, 0, 0); tick();
        chk("youngest.A", FWD_SEL_A, 2'b01);
        chk("youngest.B", FWD_SEL_B, 2'b01);

        // Producer two ahead: WB
        drain();
        issue(0, 0, 5, 1, 0); tick();
        issue(0, 0, 0, 0, 0); tick();
        issue(0, 5, 0, 0, 0); tick();
        chk("two_ahead.A", FWD_SEL_A, 2'b00);
        chk("two_ahead.B", FWD_SEL_B, 2'b10);

        // Producer three ahead: PWB or register file
        drain();
        issue(0, 0, 5, 1, 0); tick();
        issue(0, 0, 0, 0, 0); tick();
        issue(0, 0, 0, 0, 0); tick();
        issue(5, 0, 0, 0, 0); tick();
`ifdef FWD_POST_WB_EN
        chk("three_ahead.A", FWD_SEL_A, 2'b11);
`else
        chk("three_ahead.A", FWD_SEL_A, 2'b00);
`endif

        // Load-use: one stall cycle, bubble, then WB forwarding on B
        drain();
        issue(0, 0, 7, 1, 1); tick();
        issue(0, 7, 9, 1, 0);
        chk3("lu.stall", 2'b00, 2'b00, 1'b1);
        tick();
        chk3("lu.bubble", 2'b00, 2'b00, 1'b0);
        tick();
        chk3("lu.fwd", 2'b00, 2'b10, 1'b0);

        // x0 is never forwarded or stalled on
        drain();
        issue(0, 0, 0, 1, 1); tick();
        issue(0, 0, 3, 1, 0);
        chk("x0.stall", {1'b0, STALL}, 2'b00);
        tick();
        chk3("x0.sel", 2'b00, 2'b00, 1'b0);

        // HOLD for three cycles with a pending load-use hazard
        drain();
        issue(0, 0, 5, 1, 0); tick();
        issue(5, 0, 6, 1, 1); tick();
        issue(6, 0, 0, 0, 0);
        chk3("pre_hold", 2'b01, 2'b00, 1'b1);
        HOLD = 1'b1; #1;
        chk3("hold0", 2'b01, 2'b00, 1'b0);
        tick(); chk3("hold1", 2'b01, 2'b00, 1'b0);
        tick(); chk3("hold2", 2'b01, 2'b00, 1'b0);
        tick(); chk3("hold3", 2'b01, 2'b00, 1'b0);
        HOLD = 1'b0; #1;
        chk3("release", 2'b01, 2'b00, 1'b1);
        tick(); chk3("release.bubble", 2'b00, 2'b00, 1'b0);
        tick(); chk3("release.fwd", 2'b10, 2'b00, 1'b0);

        // Flushed producer must not forward
        drain();
        FLUSH = 1'b1;
        issue(0, 0, 5, 1, 0); tick();
        FLUSH = 1'b0;
        issue(5, 5, 0, 0, 0); tick();
        chk3("flush", 2'b00, 2'b00, 1'b0);

        // Asynchronous reset mid-cycle with live selects and stall
        issue(0, 0, 8, 1, 0); tick();
        issue(8, 8, 9, 1, 1); tick();
        issue(9, 0, 0, 0, 0);
        chk3("pre_reset", 2'b01, 2'b01, 1'b1);
        #2;
        RESET = 1'b0;
        #1;
        chk3("async_reset", 2'b00, 2'b00, 1'b0);
        #1;
        RESET = 1'b1;
        tick();
        chk3("resume", 2'b00, 2'b00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
